// File: rtl/food_pkg.sv
// Shared types and constants for the food placer: FSM states, LFSR tap table
// and the default game-field geometry.
package food_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_QUERY  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam int unsigned FIELD_H_MAX      = 160;
  localparam int unsigned FIELD_V_MAX      = 120;
  localparam int unsigned FIELD_H_FALLBACK = 80;
  localparam int unsigned FIELD_V_FALLBACK = 60;
  localparam int unsigned FIELD_H_RESET    = 30;
  localparam int unsigned FIELD_V_RESET    = 20;

  // Maximal-length Fibonacci tap masks: bit (t-1) set for tap t.
  function automatic logic [23:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       return 24'h0000B8;
      9:       return 24'h000110;
      10:      return 24'h000240;
      11:      return 24'h000500;
      12:      return 24'h000829;
      13:      return 24'h00100D;
      14:      return 24'h002015;
      15:      return 24'h006000;
      16:      return 24'h00B400;
      17:      return 24'h012000;
      18:      return 24'h020400;
      19:      return 24'h040023;
      20:      return 24'h090000;
      21:      return 24'h140000;
      22:      return 24'h300000;
      23:      return 24'h420000;
      24:      return 24'hE10000;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/food_placer_lfsr_gen.sv
// Free-running Fibonacci LFSR, shifting toward the MSB with XOR feedback into
// bit 0. Only the low OUT_W bits are exported.
module lfsr_gen #(
  parameter int unsigned W     = 16,
  parameter int unsigned OUT_W = W,
  parameter logic [W-1:0] SEED = W'(16'hACE1),
  parameter logic [W-1:0] TAPS = W'(16'hB400)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  output logic [OUT_W-1:0] OUT
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (CE) lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge CLK) begin
    if (RESET) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign OUT = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/food_placer.sv
// Food position generator: rejection-samples LFSR draws into the playfield,
// optionally checks the snake body, and falls back to a fixed cell.
//
// state  | meaning
// IDLE   | holding committed cell; start on NEXT, pending or refresh
// DRAW   | test the current LFSR draw against the field bounds
// QUERY  | OCC_REQ high, waiting for the snake-body answer
// COMMIT | load candidate or fallback into the outputs, pulse DONE
module food_placer
  import food_pkg::*;
#(
  parameter int unsigned H_W        = 8,
  parameter int unsigned V_W        = 7,
  parameter int unsigned H_MAX      = FIELD_H_MAX,
  parameter int unsigned V_MAX      = FIELD_V_MAX,
  parameter int unsigned H_RESET    = FIELD_H_RESET,
  parameter int unsigned V_RESET    = FIELD_V_RESET,
  parameter int unsigned H_FALLBACK = FIELD_H_FALLBACK,
  parameter int unsigned V_FALLBACK = FIELD_V_FALLBACK,
  parameter int unsigned MAX_TRIES  = 8,
  parameter bit          USE_OCC    = 1'b1,
  parameter int unsigned LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1),
  parameter logic [1:0]  IDLE_STATE = 2'b00
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           NEXT,
  input  logic [1:0]     MASTER_STATE,
  output logic           OCC_REQ,
  output logic [H_W-1:0] OCC_X,
  output logic [V_W-1:0] OCC_Y,
  input  logic           OCC_ACK,
  input  logic           OCC_HIT,
  output logic [H_W-1:0] HORIZONTAL,
  output logic [V_W-1:0] VERTICAL,
  output logic           BUSY,
  output logic           DONE,
  output logic           FALLBACK
);

  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES);
  // One extra bit so a bound equal to 2**W still admits every draw.
  localparam logic [H_W:0] H_LIM = (H_W + 1)'(H_MAX);
  localparam logic [V_W:0] V_LIM = (V_W + 1)'(V_MAX);
  localparam logic [23:0] TAP_ROW = lfsr_taps(LFSR_W);

  logic [H_W+V_W-1:0] rnd;
  logic [H_W-1:0]     cand_x;
  logic [V_W-1:0]     cand_y;
  logic               cand_ok;
  logic               start;
  logic [TW-1:0]      tries_inc;
  logic               give_up;

  state_e         state_q, state_d;
  logic [TW-1:0]  tries_q, tries_d;
  logic           pending_q, pending_d;
  logic           sel_fb_q, sel_fb_d;
  logic           occ_req_q, occ_req_d;
  logic [H_W-1:0] occ_x_q, occ_x_d;
  logic [V_W-1:0] occ_y_q, occ_y_d;
  logic [H_W-1:0] horiz_q, horiz_d;
  logic [V_W-1:0] vert_q, vert_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           fallback_q, fallback_d;

  lfsr_gen #(
    .W    (LFSR_W),
    .OUT_W(H_W + V_W),
    .SEED (SEED),
    .TAPS (TAP_ROW[LFSR_W-1:0])
  ) u_lfsr (
    .CLK  (CLK),
    .RESET(RESET),
    .CE   (1'b1),
    .OUT  (rnd)
  );

  assign cand_x    = rnd[H_W-1:0];
  assign cand_y    = rnd[H_W+V_W-1:H_W];
  assign cand_ok   = ({1'b0, cand_x} < H_LIM) && ({1'b0, cand_y} < V_LIM);
  assign start     = NEXT | pending_q | (MASTER_STATE == IDLE_STATE);
  assign tries_inc = tries_q + TW'(1);
  assign give_up   = (tries_inc == TRIES_LAST);

  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    pending_d  = pending_q;
    sel_fb_d   = sel_fb_q;
    occ_req_d  = occ_req_q;
    occ_x_d    = occ_x_q;
    occ_y_d    = occ_y_q;
    horiz_d    = horiz_q;
    vert_d     = vert_q;
    done_d     = 1'b0;
    fallback_d = 1'b0;

    // Requests arriving mid-placement collapse into a single pending start.
    if (NEXT && (state_q != ST_IDLE)) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_DRAW;
          tries_d   = '0;
          pending_d = 1'b0;
          sel_fb_d  = 1'b0;
        end
      end
      ST_DRAW: begin
        if (cand_ok) begin
          occ_x_d = cand_x;
          occ_y_d = cand_y;
          if (USE_OCC) begin
            occ_req_d = 1'b1;
            state_d   = ST_QUERY;
          end else begin
            state_d = ST_COMMIT;
          end
        end else begin
          tries_d = tries_inc;
          if (give_up) begin
            sel_fb_d = 1'b1;
            state_d  = ST_COMMIT;
          end
        end
      end
      ST_QUERY: begin
        if (OCC_ACK) begin
          occ_req_d = 1'b0;
          if (!OCC_HIT) begin
            state_d = ST_COMMIT;
          end else begin
            tries_d = tries_inc;
            if (give_up) begin
              sel_fb_d = 1'b1;
              state_d  = ST_COMMIT;
            end else begin
              state_d = ST_DRAW;
            end
          end
        end
      end
      ST_COMMIT: begin
        horiz_d    = sel_fb_q ? H_W'(H_FALLBACK) : occ_x_q;
        vert_d     = sel_fb_q ? V_W'(V_FALLBACK) : occ_y_q;
        done_d     = 1'b1;
        fallback_d = sel_fb_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      tries_q    <= '0;
      pending_q  <= 1'b0;
      sel_fb_q   <= 1'b0;
      occ_req_q  <= 1'b0;
      occ_x_q    <= '0;
      occ_y_q    <= '0;
      horiz_q    <= H_W'(H_RESET);
      vert_q     <= V_W'(V_RESET);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      pending_q  <= pending_d;
      sel_fb_q   <= sel_fb_d;
      occ_req_q  <= occ_req_d;
      occ_x_q    <= occ_x_d;
      occ_y_q    <= occ_y_d;
      horiz_q    <= horiz_d;
      vert_q     <= vert_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fallback_q <= fallback_d;
    end
  end

  assign OCC_REQ    = occ_req_q;
  assign OCC_X      = occ_x_q;
  assign OCC_Y      = occ_y_q;
  assign HORIZONTAL = horiz_q;
  assign VERTICAL   = vert_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign FALLBACK   = fallback_q;

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: three instances (occupancy on, occupancy off, 1x1 field)
// checked against a placement model built from an independent LFSR sequence.
module tb_food_placer;

  localparam int MAX_TRIES = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic zero = 1'b0;

  logic next_a = 1'b0, next_n = 1'b0, next_t = 1'b0;
  logic [1:0] ms_a = 2'b01, ms_n = 2'b01, ms_t = 2'b01;
  logic ack_a = 1'b0, hit_a = 1'b0;

  logic req_a, req_n, req_t;
  logic [7:0] ox_a, ox_n, ox_t, h_a, h_n, h_t;
  logic [6:0] oy_a, oy_n, oy_t, v_a, v_n, v_t;
  logic busy_a, busy_n, busy_t, done_a, done_n, done_t, fb_a, fb_n, fb_t;

  int n_vec = 0;
  int n_err = 0;

  food_placer dut_a (
    .CLK(CLK), .RESET(RESET), .NEXT(next_a), .MASTER_STATE(ms_a),
    .OCC_REQ(req_a), .OCC_X(ox_a), .OCC_Y(oy_a), .OCC_ACK(ack_a), .OCC_HIT(hit_a),
    .HORIZONTAL(h_a), .VERTICAL(v_a), .BUSY(busy_a), .DONE(done_a), .FALLBACK(fb_a));

  food_placer #(.USE_OCC(1'b0)) dut_n (
    .CLK(CLK), .RESET(RESET), .NEXT(next_n), .MASTER_STATE(ms_n),
    .OCC_REQ(req_n), .OCC_X(ox_n), .OCC_Y(oy_n), .OCC_ACK(zero), .OCC_HIT(zero),
    .HORIZONTAL(h_n), .VERTICAL(v_n), .BUSY(busy_n), .DONE(done_n), .FALLBACK(fb_n));

  food_placer #(.H_MAX(1), .V_MAX(1), .USE_OCC(1'b0)) dut_t (
    .CLK(CLK), .RESET(RESET), .NEXT(next_t), .MASTER_STATE(ms_t),
    .OCC_REQ(req_t), .OCC_X(ox_t), .OCC_Y(oy_t), .OCC_ACK(zero), .OCC_HIT(zero),
    .HORIZONTAL(h_t), .VERTICAL(v_t), .BUSY(busy_t), .DONE(done_t), .FALLBACK(fb_t));

  always #5 CLK = ~CLK;

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, new bit enters at the LSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge CLK) m_lfsr <= RESET ? SEED : lfsr_step(m_lfsr);

  // Placement outcome when the start edge follows a cycle holding LFSR value l0
  // and every query is answered "free" immediately. elat counts clock edges
  // from the start edge to the first cycle DONE is high.
  function automatic void predict(input logic [15:0] l0, input int hmax, input int vmax,
                                  input bit use_occ, output int ex, output int ey,
                                  output bit efb, output int elat);
    logic [15:0] s;
    s = l0;
    for (int i = 1; i <= MAX_TRIES; i++) begin
      s = lfsr_step(s);
      if (int'(s[7:0]) < hmax && int'(s[14:8]) < vmax) begin
        ex = int'(s[7:0]); ey = int'(s[14:8]); efb = 1'b0;
        elat = i + (use_occ ? 2 : 1);
        return;
      end
    end
    ex = 80; ey = 60; efb = 1'b1; elat = MAX_TRIES + 1;
  endfunction

  // Snake-body stand-in: acks after ack_delay cycles of OCC_REQ, answers hit_val.
  int ack_delay = 0;
  logic hit_val = 1'b0;
  int req_cnt = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  always @(negedge CLK) begin
    if (req_a && !req_prev) req_rises++;
    req_prev = req_a;
    if (req_a) begin
      ack_a = (req_cnt >= ack_delay);
      hit_a = hit_val;
      req_cnt++;
    end else begin
      ack_a = 1'b0;
      hit_a = 1'b0;
      req_cnt = 0;
    end
  end

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    n_vec++; if (h_a !== 8'd30 || v_a !== 7'd20) begin n_err++; $display("FAIL reset_pos got %0d,%0d want 30,20", h_a, v_a); end
    n_vec++; if (busy_a !== 1'b0 || done_a !== 1'b0 || fb_a !== 1'b0) begin n_err++; $display("FAIL reset_flags got busy=%b done=%b fb=%b want 0,0,0", busy_a, done_a, fb_a); end
    n_vec++; if (req_a !== 1'b0 || ox_a !== 8'd0 || oy_a !== 7'd0) begin n_err++; $display("FAIL reset_occ got req=%b x=%0d y=%0d want 0,0,0", req_a, ox_a, oy_a); end
    n_vec++; if (h_t !== 8'd30 || v_t !== 7'd20) begin n_err++; $display("FAIL reset_pos_t got %0d,%0d want 30,20", h_t, v_t); end
  endtask

  task automatic test_single_next();
    logic [15:0] l;
    int ex, ey, elat, lat;
    bit efb;
    hit_val = 1'b0; ack_delay = 0;
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 15)) @(negedge CLK);
      l = m_lfsr;
      next_a = 1'b1;
      predict(l, 160, 120, 1'b1, ex, ey, efb, elat);
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
        @(negedge CLK);
        next_a = 1'b0;
        if (c == 1) begin
          n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy_a); end
        end
        if (req_a) begin
          n_vec++; if (ox_a !== 8'(ex) || oy_a !== 7'(ey)) begin n_err++; $display("FAIL single_query got %0d,%0d want %0d,%0d", ox_a, oy_a, ex, ey); end
        end
        if (done_a) begin lat = c - 1; break; end
      end
      n_vec++; if (lat != elat) begin n_err++; $display("FAIL single_latency got %0d want %0d", lat, elat); end
      n_vec++; if (h_a !== 8'(ex) || v_a !== 7'(ey) || fb_a !== efb) begin n_err++; $display("FAIL single_pos got %0d,%0d fb=%b want %0d,%0d fb=%b", h_a, v_a, fb_a, ex, ey, efb); end
      n_vec++; if (!fb_a && (h_a >= 8'd160 || v_a >= 7'd120)) begin n_err++; $display("FAIL single_range got %0d,%0d want below 160,120", h_a, v_a); end
      n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got %b want 0", busy_a); end
      @(negedge CLK);
      n_vec++; if (done_a !== 1'b0 || fb_a !== 1'b0) begin n_err++; $display("FAIL single_pulse got done=%b fb=%b want 0,0", done_a, fb_a); end
    end
  endtask

  task automatic test_all_hit();
    int lat;
    hit_val = 1'b1; ack_delay = 0; req_rises = 0;
    next_a = 1'b1;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      next_a = 1'b0;
      if (done_a) begin lat = c - 1; break; end
    end
    n_vec++; if (lat < MAX_TRIES + 1 || lat > 2 * MAX_TRIES + 1) begin n_err++; $display("FAIL hit_latency got %0d want 9..17", lat); end
    n_vec++; if (fb_a !== 1'b1 || h_a !== 8'd80 || v_a !== 7'd60) begin n_err++; $display("FAIL hit_fallback got %0d,%0d fb=%b want 80,60 fb=1", h_a, v_a, fb_a); end
    n_vec++; if (req_rises > MAX_TRIES) begin n_err++; $display("FAIL hit_queries got %0d want <= %0d", req_rises, MAX_TRIES); end
    hit_val = 1'b0;
  endtask

  task automatic test_reset_mid_query();
    bit got_req;
    int dones;
    hit_val = 1'b0; ack_delay = 1000;
    got_req = 1'b0;
    next_a = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      next_a = 1'b0;
      if (req_a) begin got_req = 1'b1; break; end
    end
    n_vec++; if (got_req !== 1'b1) begin n_err++; $display("FAIL midq_reach got req=%b want 1", got_req); end
    RESET = 1'b1;
    @(negedge CLK);
    n_vec++; if (h_a !== 8'd30 || v_a !== 7'd20) begin n_err++; $display("FAIL midq_pos got %0d,%0d want 30,20", h_a, v_a); end
    n_vec++; if (busy_a !== 1'b0 || done_a !== 1'b0 || req_a !== 1'b0) begin n_err++; $display("FAIL midq_flags got busy=%b done=%b req=%b want 0,0,0", busy_a, done_a, req_a); end
    RESET = 1'b0;
    ack_delay = 0;
    dones = 0;
    repeat (20) begin
      @(negedge CLK);
      if (done_a) dones++;
    end
    n_vec++; if (dones != 0) begin n_err++; $display("FAIL midq_nodone got %0d want 0", dones); end
  endtask

  task automatic test_back_to_back();
    int dones, first_c;
    hit_val = 1'b0; ack_delay = 5;
    dones = 0; first_c = -10;
    next_a = 1'b1;
    for (int c = 1; c <= 160; c++) begin
      @(negedge CLK);
      next_a = (c == 2 || c == 4 || c == 6);
      if (c == first_c + 1) begin
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL b2b_restart got busy=%b want 1", busy_a); end
      end
      if (done_a) begin
        dones++;
        if (dones == 1) first_c = c;
      end
    end
    n_vec++; if (dones != 2) begin n_err++; $display("FAIL b2b_dones got %0d want 2", dones); end
    ack_delay = 0;
  endtask

  task automatic test_refresh();
    logic [15:0] l;
    int ex, ey, elat, lat, total, dones;
    bit efb, last, stop, moved;
    total = 0; last = 1'b0; stop = 1'b0;
    @(negedge CLK);
    l = m_lfsr;
    ms_n = 2'b00;
    while (!stop) begin
      predict(l, 160, 120, 1'b0, ex, ey, efb, elat);
      lat = -1;
      for (int c = 1; c <= 12; c++) begin
        @(negedge CLK);
        if (last && c == 1) ms_n = 2'b01;
        if (done_n) begin lat = c - 1; break; end
      end
      n_vec++; if (lat != elat) begin n_err++; $display("FAIL refresh_latency got %0d want %0d", lat, elat); end
      n_vec++; if (lat < 0 || lat + 1 > MAX_TRIES + 2) begin n_err++; $display("FAIL refresh_gap got %0d want <= %0d", lat + 1, MAX_TRIES + 2); end
      n_vec++; if (h_n !== 8'(ex) || v_n !== 7'(ey) || fb_n !== efb) begin n_err++; $display("FAIL refresh_pos got %0d,%0d fb=%b want %0d,%0d fb=%b", h_n, v_n, fb_n, ex, ey, efb); end
      if (last || lat < 0) stop = 1'b1;
      total += lat + 1;
      l = m_lfsr;
      if (total >= 50) last = 1'b1;
    end
    dones = 0; moved = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      if (done_n) dones++;
      if (h_n !== 8'(ex) || v_n !== 7'(ey)) moved = 1'b1;
    end
    n_vec++; if (dones != 0 || moved) begin n_err++; $display("FAIL refresh_freeze got dones=%0d moved=%b want 0,0", dones, moved); end
    n_vec++; if (req_n !== 1'b0) begin n_err++; $display("FAIL refresh_noreq got %b want 0", req_n); end
  endtask

  task automatic test_tiny_field();
    logic [15:0] l;
    int ex, ey, elat, lat;
    bit efb, saw_req;
    saw_req = 1'b0;
    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(0, 20)) @(negedge CLK);
      l = m_lfsr;
      next_t = 1'b1;
      predict(l, 1, 1, 1'b0, ex, ey, efb, elat);
      lat = -1;
      for (int c = 1; c <= 12; c++) begin
        @(negedge CLK);
        next_t = 1'b0;
        if (req_t) saw_req = 1'b1;
        if (done_t) begin lat = c - 1; break; end
      end
      n_vec++; if (lat != elat || lat > MAX_TRIES + 1) begin n_err++; $display("FAIL tiny_latency got %0d want %0d", lat, elat); end
      n_vec++; if (h_t !== 8'(ex) || v_t !== 7'(ey) || fb_t !== efb) begin n_err++; $display("FAIL tiny_pos got %0d,%0d fb=%b want %0d,%0d fb=%b", h_t, v_t, fb_t, ex, ey, efb); end
    end
    n_vec++; if (saw_req !== 1'b0) begin n_err++; $display("FAIL tiny_noreq got %b want 0", saw_req); end
  endtask

  initial begin
    test_reset();
    test_single_next();
    test_all_hit();
    test_reset_mid_query();
    test_back_to_back();
    test_refresh();
    test_tiny_field();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
